taillight_seq: RTL and testbench

TAILLIGHT_SEQ -- requirements
Module: taillight_seq

---
 rtl/taillight_seq.sv | 118 +++++++++++
 tb/tb_taillight_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/taillight_seq.sv
// Sequential turn-signal tail-light controller: thermometer sweep per side, hazard flash, divided step tick.
// Optional brake overlay and Brake port are compiled in when TAILLIGHT_BRAKE_EN is defined.
module taillight_seq #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 33554432
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       S,
`ifdef TAILLIGHT_BRAKE_EN
  input  logic             Brake,
`endif
  output logic [LAMPS-1:0] Left,
  output logic [LAMPS-1:0] Right,
  output logic             Tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [DW-1:0]    DIV_MAX  = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    STEP_MAX = SW'(LAMPS);
  localparam logic [LAMPS-1:0] ALL_ON   = '1;

  // Encoding matches S directly so the decode is a cast.
  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_RIGHT  = 2'b01,
    ST_LEFT   = 2'b10,
    ST_HAZARD = 2'b11
  } mode_e;

  mode_e            state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [SW-1:0]    step_q, step_d;
  logic             tick_d;
  logic             mode_change;
  logic [LAMPS-1:0] therm;
  logic [LAMPS-1:0] left_d, right_d;

  // State register: mode, divider and step counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_OFF;
      div_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
    end
  end

  // Next state: mode follows S every edge; a mode change restarts the sequence.
  always_comb begin
    state_d     = mode_e'(S);
    mode_change = (state_d != state_q);
    div_d       = div_q + DW'(1);
    step_d      = step_q;
    tick_d      = 1'b0;
    if (mode_change || state_q == ST_OFF) begin
      div_d  = '0;
      step_d = '0;
    end else if (div_q == DIV_MAX) begin
      div_d  = '0;
      tick_d = 1'b1;
      if (state_q == ST_HAZARD)
        step_d = (step_q == '0) ? SW'(1) : '0;
      else
        step_d = (step_q == STEP_MAX) ? '0 : step_q + SW'(1);
    end
  end

  // Output decode from the next mode/step so the registered lamps land on the causing edge.
  always_comb begin
    therm   = ~(ALL_ON << step_d);
    left_d  = '0;
    right_d = '0;
    case (state_d)
      ST_RIGHT:  right_d = therm;
      ST_LEFT:   left_d  = therm;
      ST_HAZARD: begin
        left_d  = (step_d != '0) ? ALL_ON : '0;
        right_d = (step_d != '0) ? ALL_ON : '0;
      end
      default: begin
        left_d  = '0;
        right_d = '0;
      end
    endcase
`ifdef TAILLIGHT_BRAKE_EN
    // Brake lights whichever side is idle; hazard flashing wins over brake.
    if (Brake) begin
      case (state_d)
        ST_OFF: begin
          left_d  = ALL_ON;
          right_d = ALL_ON;
        end
        ST_RIGHT: left_d  = ALL_ON;
        ST_LEFT:  right_d = ALL_ON;
        default:  ;
      endcase
    end
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Left  <= '0;
      Right <= '0;
      Tick  <= 1'b0;
    end else begin
      Left  <= left_d;
      Right <= right_d;
      Tick  <= tick_d;
    end
  end

endmodule

// File: tb/tb_taillight_seq.sv
// Directed bench for taillight_seq with LAMPS=3, TICK_DIV=4; brake cases build when TAILLIGHT_BRAKE_EN is defined.
module tb_taillight_seq;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [1:0] S;
  logic       Brake;
  logic [2:0] Left, Right;
  logic       Tick;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] r_tab [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

  taillight_seq #(.LAMPS(3), .TICK_DIV(4)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .S     (S),
`ifdef TAILLIGHT_BRAKE_EN
    .Brake (Brake),
`endif
    .Left  (Left),
    .Right (Right),
    .Tick  (Tick)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check_lr(input string tag, input logic [2:0] l, input logic [2:0] r, input logic t);
    check({tag, "_left"},  32'(Left),  32'(l));
    check({tag, "_right"}, 32'(Right), 32'(r));
    check({tag, "_tick"},  32'(Tick),  32'(t));
  endtask

  initial begin
    Rst = 1'b1; S = 2'b00; Brake = 1'b0;
    cyc(2);
    check_lr("reset", 3'b000, 3'b000, 1'b0);
    S = 2'b01;
    cyc(1);
    check_lr("reset_s01", 3'b000, 3'b000, 1'b0);

    // Right sweep from release; k counts edges after release.
    Rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      cyc(1);
      check_lr("right_seq", 3'b000, r_tab[(k / 4) % 4], (k != 0) && (k % 4 == 0));
    end

    // Move to step 2 then switch to left.
    cyc(9);
    check_lr("right_step2", 3'b000, 3'b011, 1'b0);
    S = 2'b10;
    cyc(1);
    check_lr("chg_first", 3'b000, 3'b000, 1'b0);
    cyc(3);
    check_lr("chg_plus3", 3'b000, 3'b000, 1'b0);
    cyc(1);
    check_lr("chg_plus4", 3'b001, 3'b000, 1'b1);
    cyc(4);
    check_lr("left_s2", 3'b011, 3'b000, 1'b1);
    cyc(4);
    check_lr("left_s3", 3'b111, 3'b000, 1'b1);
    cyc(4);
    check_lr("left_wrap", 3'b000, 3'b000, 1'b1);

    // Hazard flashes both sides in phase.
    S = 2'b11;
    cyc(1);
    check_lr("haz_0", 3'b000, 3'b000, 1'b0);
    cyc(4);
    check_lr("haz_1", 3'b111, 3'b111, 1'b1);
    cyc(4);
    check_lr("haz_2", 3'b000, 3'b000, 1'b1);
    cyc(4);
    check_lr("haz_3", 3'b111, 3'b111, 1'b1);

    // Asynchronous reset at step 3.
    S = 2'b01;
    cyc(1);
    check_lr("pre_rst0", 3'b000, 3'b000, 1'b0);
    cyc(12);
    check_lr("pre_rst3", 3'b000, 3'b111, 1'b1);
    #2 Rst = 1'b1;
    #1;
    check_lr("async_rst", 3'b000, 3'b000, 1'b0);
    cyc(2);
    check_lr("rst_hold", 3'b000, 3'b000, 1'b0);
    Rst = 1'b0;
    cyc(1);
    check_lr("post_rst0", 3'b000, 3'b000, 1'b0);
    cyc(3);
    check_lr("post_rst3", 3'b000, 3'b000, 1'b0);
    cyc(1);
    check_lr("post_rst4", 3'b000, 3'b001, 1'b1);

    // Fast toggling of S keeps step at 0.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) S = (S == 2'b01) ? 2'b10 : 2'b01;
      cyc(1);
      check_lr("toggle", 3'b000, 3'b000, 1'b0);
    end

    S = 2'b00;
    cyc(1);
    check_lr("off_0", 3'b000, 3'b000, 1'b0);
    cyc(6);
    check_lr("off_6", 3'b000, 3'b000, 1'b0);

`ifdef TAILLIGHT_BRAKE_EN
    Brake = 1'b1;
    cyc(1);
    check_lr("brk_off", 3'b111, 3'b111, 1'b0);
    S = 2'b01;
    cyc(1);
    check_lr("brk_right0", 3'b111, 3'b000, 1'b0);
    cyc(4);
    check_lr("brk_right1", 3'b111, 3'b001, 1'b1);
    S = 2'b10;
    cyc(1);
    check_lr("brk_left0", 3'b000, 3'b111, 1'b0);
    S = 2'b11;
    cyc(1);
    check_lr("brk_haz0", 3'b000, 3'b000, 1'b0);
    cyc(4);
    check_lr("brk_haz1", 3'b111, 3'b111, 1'b1);
    Brake = 1'b0;
    S = 2'b00;
    cyc(1);
    check_lr("brk_release", 3'b000, 3'b000, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
